// File: rtl/nivel2_timer.sv
// nivel2_timer: MM:SS BCD cook-time countdown for the level-2 microwave.
// Rev 1.0 - initial release.
`default_nettype none

module nivel2_timer #(
  parameter int TICK_DIV = 100,
  parameter int CNT_W    = 7
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clearn,
  input  logic       load,
  input  logic [3:0] digit,
  input  logic       enable,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       tick,
  output logic       timer_done
);

  localparam logic [1:0]       c_zero    = 2'd0;
  localparam logic [1:0]       c_armed   = 2'd1;
  localparam logic [1:0]       c_running = 2'd2;
  localparam logic [CNT_W-1:0] c_wrap    = CNT_W'(TICK_DIV - 1);

  logic [1:0]       r_state, w_state;
  logic [CNT_W-1:0] r_presc, w_presc;
  logic [3:0]       r_mt, r_mo, r_st, r_so;
  logic [3:0]       w_mt, w_mo, w_st, w_so;
  logic             r_tick, w_tick;
  logic             r_done, w_done;
  logic             w_load_ok;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= c_zero;
      r_presc <= '0;
      r_mt    <= 4'd0;
      r_mo    <= 4'd0;
      r_st    <= 4'd0;
      r_so    <= 4'd0;
      r_tick  <= 1'b0;
      r_done  <= 1'b1;
    end else begin
      r_state <= w_state;
      r_presc <= w_presc;
      r_mt    <= w_mt;
      r_mo    <= w_mo;
      r_st    <= w_st;
      r_so    <= w_so;
      r_tick  <= w_tick;
      r_done  <= w_done;
    end
  end

  assign w_load_ok = load && !enable && (digit <= 4'd9);

  // State ZERO is kept in lockstep with the digits, so it doubles as the all-zero flag.
  always_comb begin
    w_presc = r_presc;
    w_mt    = r_mt;
    w_mo    = r_mo;
    w_st    = r_st;
    w_so    = r_so;
    w_tick  = 1'b0;
    if (!clearn) begin
      w_presc = '0;
      w_mt    = 4'd0;
      w_mo    = 4'd0;
      w_st    = 4'd0;
      w_so    = 4'd0;
    end else if (w_load_ok) begin
      w_mt = r_mo;
      w_mo = r_st;
      w_st = r_so;
      w_so = digit;
    end else if (enable && (r_state != c_zero)) begin
      if (r_presc == c_wrap) begin
        w_presc = '0;
        w_tick  = 1'b1;
        if (r_so != 4'd0) begin
          w_so = r_so - 4'd1;
        end else begin
          w_so = 4'd9;
          if (r_st != 4'd0) begin
            w_st = r_st - 4'd1;
          end else begin
            w_st = 4'd5;
            if (r_mo != 4'd0) begin
              w_mo = r_mo - 4'd1;
            end else begin
              w_mo = 4'd9;
              w_mt = r_mt - 4'd1;
            end
          end
        end
      end else begin
        w_presc = r_presc + 1'b1;
      end
    end else if (r_state == c_zero) begin
      w_presc = '0;
    end
    w_done = (w_mt == 4'd0) && (w_mo == 4'd0) && (w_st == 4'd0) && (w_so == 4'd0);
    if (w_done) begin
      w_state = c_zero;
    end else if (enable) begin
      w_state = c_running;
    end else begin
      w_state = c_armed;
    end
  end

  always_comb begin
    min_tens   = r_mt;
    min_ones   = r_mo;
    sec_tens   = r_st;
    sec_ones   = r_so;
    tick       = r_tick;
    timer_done = r_done;
  end

endmodule

`default_nettype wire

// File: tb/tb_nivel2_timer.sv
// tb_nivel2_timer: directed scoreboard bench for nivel2_timer at TICK_DIV=4.
`default_nettype none

module tb_nivel2_timer;

  logic       clk = 1'b0;
  logic       rstn, clearn, load, enable;
  logic [3:0] digit;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       tick, timer_done;

  typedef struct {
    string       tag;
    logic [17:0] val;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  nivel2_timer #(.TICK_DIV(4), .CNT_W(3)) dut (
    .clk(clk), .rstn(rstn), .clearn(clearn), .load(load), .digit(digit),
    .enable(enable), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .tick(tick), .timer_done(timer_done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input string tag, input logic [15:0] t, input logic tk, input logic dn);
    exp_t e;
    e.tag = tag;
    e.val = {t, tk, dn};
    q.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [17:0] obs;
    obs = {min_tens, min_ones, sec_tens, sec_ones, tick, timer_done};
    n_tests++;
    if (q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed time=%h tick=%b done=%b expected time=%h tick=%b done=%b",
               e.tag, obs[17:2], obs[1], obs[0], e.val[17:2], e.val[1], e.val[0]);
      end
    end
  endtask

  task automatic step(input string tag, input logic [15:0] t, input logic tk, input logic dn);
    push(tag, t, tk, dn);
    @(posedge clk);
    #1;
    check();
  endtask

  task automatic load_digit(input string tag, input logic [3:0] d, input logic [15:0] t);
    load  = 1'b1;
    digit = d;
    step(tag, t, 1'b0, (t == 16'h0000));
    load  = 1'b0;
  endtask

  task automatic clear();
    clearn = 1'b0;
    step("clear", 16'h0000, 1'b0, 1'b1);
    clearn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; clearn = 1'b1; load = 1'b0; digit = 4'd0; enable = 1'b0;
    #22;
    push("reset", 16'h0000, 1'b0, 1'b1);
    check();
    @(posedge clk); #1;
    rstn = 1'b1;

    // Digit entry shifts in from the right.
    load_digit("ld1", 4'd1, 16'h0001);
    load_digit("ld3", 4'd3, 16'h0013);
    load_digit("ld0", 4'd0, 16'h0130);

    // Loads while running and out-of-range digits are ignored.
    enable = 1'b1; load = 1'b1; digit = 4'd7;
    step("en_ld7", 16'h0130, 1'b0, 1'b0);
    digit = 4'd12;
    step("en_ld12", 16'h0130, 1'b0, 1'b0);
    enable = 1'b0;
    step("ld12", 16'h0130, 1'b0, 1'b0);
    load = 1'b0;
    clear();

    // 00:02 runs to zero; no tick after done.
    load_digit("ld2", 4'd2, 16'h0002);
    enable = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      if (i < 4)       step("run2_pre",  16'h0002, 1'b0, 1'b0);
      else if (i == 4) step("run2_t1",   16'h0001, 1'b1, 1'b0);
      else if (i < 8)  step("run2_mid",  16'h0001, 1'b0, 1'b0);
      else if (i == 8) step("run2_t2",   16'h0000, 1'b1, 1'b1);
      else             step("run2_post", 16'h0000, 1'b0, 1'b1);
    end
    enable = 1'b0;

    // 01:00 -> 00:59 borrow chain.
    load_digit("ld1b", 4'd1, 16'h0001);
    load_digit("ld0b", 4'd0, 16'h0010);
    load_digit("ld0c", 4'd0, 16'h0100);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) step("b100_pre", 16'h0100, 1'b0, 1'b0);
    step("b100_tick", 16'h0059, 1'b1, 1'b0);
    enable = 1'b0;
    step("b100_hold", 16'h0059, 1'b0, 1'b0);
    clear();

    // 10:00 -> 09:59 full borrow.
    load_digit("ld1c", 4'd1, 16'h0001);
    load_digit("ld0d", 4'd0, 16'h0010);
    load_digit("ld0e", 4'd0, 16'h0100);
    load_digit("ld0f", 4'd0, 16'h1000);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) step("b1000_pre", 16'h1000, 1'b0, 1'b0);
    step("b1000_tick", 16'h0959, 1'b1, 1'b0);
    enable = 1'b0;
    clear();

    // Pause keeps the partial second.
    load_digit("ld5", 4'd5, 16'h0005);
    enable = 1'b1;
    for (int i = 0; i < 2; i++) step("pause_run", 16'h0005, 1'b0, 1'b0);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) step("pause_hold", 16'h0005, 1'b0, 1'b0);
    enable = 1'b1;
    step("resume_1", 16'h0005, 1'b0, 1'b0);
    step("resume_tick", 16'h0004, 1'b1, 1'b0);
    enable = 1'b0;
    clear();

    // Clear while running, and clear beats load.
    load_digit("ld3b", 4'd3, 16'h0003);
    load_digit("ld0g", 4'd0, 16'h0030);
    load_digit("ld0h", 4'd0, 16'h0300);
    enable = 1'b1;
    for (int i = 0; i < 2; i++) step("clr_run_pre", 16'h0300, 1'b0, 1'b0);
    clearn = 1'b0;
    step("clr_run", 16'h0000, 1'b0, 1'b1);
    clearn = 1'b1; enable = 1'b0;
    load = 1'b1; digit = 4'd5; clearn = 1'b0;
    step("clr_vs_load", 16'h0000, 1'b0, 1'b1);
    load = 1'b0; clearn = 1'b1;

    // Asynchronous reset mid-cycle.
    load_digit("ld4", 4'd4, 16'h0004);
    enable = 1'b1;
    step("arst_pre", 16'h0004, 1'b0, 1'b0);
    #3;
    rstn = 1'b0;
    #1;
    push("async_rst", 16'h0000, 1'b0, 1'b1);
    check();
    enable = 1'b0;
    #2;
    rstn = 1'b1;

    // 00:90 counts down through 00:89.
    load_digit("ld9", 4'd9, 16'h0009);
    load_digit("ld0i", 4'd0, 16'h0090);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) step("s90_pre", 16'h0090, 1'b0, 1'b0);
    step("s90_tick", 16'h0089, 1'b1, 1'b0);
    enable = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
